// File: rtl/hough_pkg.sv
// Shared Q-format constants, sweep FSM state type and elaboration-time helpers
// for the Hough rho sweep block and its coefficient ROM.
package hough_pkg;

    localparam int     COEF_W_DEF = 16;
    localparam int     COEF_FRAC  = COEF_W_DEF - 2;
    localparam longint ONE        = 64'sd1 <<< COEF_FRAC;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN
    } sweep_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // pi in Q30; the trig helpers below only run at elaboration time
    localparam longint PI_Q30 = 64'sd3373259426;

    // round(sin(pi*num/den) * 2^frac) for 0 <= num/den <= 1/2, Taylor series in Q30
    function automatic longint sin_quarter(input int num, input int den, input int frac);
        longint xa, x2, term, acc;
        xa   = (PI_Q30 * num) / den;
        x2   = (xa * xa) >>> 30;
        term = xa;
        acc  = xa;
        for (int i = 1; i <= 12; i++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * i) * (2 * i + 1)));
            acc  = acc + term;
        end
        return ((acc <<< frac) + (64'sd1 <<< 29)) >>> 30;
    endfunction

    // theta_k = pi*k/n = pi*(2k)/(2n); fold into the first quadrant so that the
    // 0, 45 and 90 degree points come out exact and mutually symmetric
    function automatic longint sin_coef_q(input int k, input int n, input int frac);
        int a;
        a = 2 * k;
        if (a <= n) return sin_quarter(a, 2 * n, frac);
        return sin_quarter(2 * n - a, 2 * n, frac);
    endfunction

    function automatic longint cos_coef_q(input int k, input int n, input int frac);
        int a;
        a = 2 * k;
        if (a <= n) return sin_quarter(n - a, 2 * n, frac);
        return -sin_quarter(a - n, 2 * n, frac);
    endfunction

endpackage

// File: rtl/hough_trig_lut.sv
// THETA_N-entry cos/sin coefficient ROM built at elaboration, registered read.
module hough_trig_lut
    import hough_pkg::*;
#(
    parameter int THETA_N = 180,
    parameter int COEF_W  = 16,
    parameter int IDX_W   = idx_w(THETA_N)
)(
    input  logic                     clk,
    input  logic                     en,
    input  logic [IDX_W-1:0]         addr,
    output logic signed [COEF_W-1:0] cos_coef,
    output logic signed [COEF_W-1:0] sin_coef
);

    logic signed [COEF_W-1:0] cos_rom [THETA_N];
    logic signed [COEF_W-1:0] sin_rom [THETA_N];

    for (genvar i = 0; i < THETA_N; i++) begin : g_rom
        localparam logic signed [COEF_W-1:0] COS_V = COEF_W'(cos_coef_q(i, THETA_N, COEF_W - 2));
        localparam logic signed [COEF_W-1:0] SIN_V = COEF_W'(sin_coef_q(i, THETA_N, COEF_W - 2));
        assign cos_rom[i] = COS_V;
        assign sin_rom[i] = SIN_V;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            cos_coef <= cos_rom[addr];
            sin_coef <= sin_rom[addr];
        end
    end

endmodule

// File: rtl/hough_rho_sweep.sv
// Sweeps one pixel through THETA_N angles, producing rho = x*cos + y*sin per
// angle through a 3-stage stallable pipeline (LUT, multiply, add/round/saturate).
module hough_rho_sweep
    import hough_pkg::*;
#(
    parameter int XY_W    = 12,
    parameter int THETA_N = 180,
    parameter int COEF_W  = 16,
    parameter int RHO_W   = XY_W + 2
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_vld,
    output logic                       in_rdy,
    input  logic [XY_W-1:0]            x,
    input  logic [XY_W-1:0]            y,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic signed [RHO_W-1:0]    rho_data,
    output logic [idx_w(THETA_N)-1:0]  theta_idx,
    output logic                       out_last
);

    localparam int IDX_W = idx_w(THETA_N);
    localparam int FRAC  = COEF_W - 2;
    localparam int PW    = XY_W + COEF_W + 1;
    localparam int SW    = PW + 1;
    localparam logic [IDX_W-1:0] KMAX = IDX_W'(THETA_N - 1);

    function automatic logic signed [SW-1:0] round_q(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] half;
        half           = '0;
        half[FRAC-1]   = 1'b1;
        return (v + half) >>> FRAC;
    endfunction

    function automatic logic signed [RHO_W-1:0] sat_rho(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] vmax, vmin;
        vmax              = '0;
        vmax[RHO_W-2:0]   = '1;
        vmin              = '1;
        vmin[RHO_W-2:0]   = '0;
        if (v > vmax) return vmax[RHO_W-1:0];
        if (v < vmin) return vmin[RHO_W-1:0];
        return v[RHO_W-1:0];
    endfunction

    sweep_state_t             state;
    logic [IDX_W-1:0]         k_cnt;
    logic [XY_W-1:0]          x_q, y_q;
    logic                     stall, adv, issue;

    logic                     vld_p1, last_p1, vld_p2, last_p2;
    logic [IDX_W-1:0]         k_p1, k_p2;
    logic signed [COEF_W-1:0] cos_p1, sin_p1;
    logic signed [PW-1:0]     x_ext, y_ext, cos_ext, sin_ext;
    logic signed [PW-1:0]     px_p2, py_p2;
    logic signed [SW-1:0]     sum_p3;

    // A result sitting unaccepted at the output freezes the whole pipe
    assign stall = out_vld && !out_rdy;
    assign adv   = !stall;
    assign issue = (state == SWEEP) && adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            in_rdy <= 1'b1;
            k_cnt  <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_vld && in_rdy) begin
                        x_q    <= x;
                        y_q    <= y;
                        k_cnt  <= '0;
                        in_rdy <= 1'b0;
                        state  <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (adv) begin
                        if (k_cnt == KMAX) state <= DRAIN;
                        else               k_cnt <= k_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_vld && out_rdy && out_last) begin
                        in_rdy <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    in_rdy <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // S1: coefficient read
    hough_trig_lut #(
        .THETA_N (THETA_N),
        .COEF_W  (COEF_W),
        .IDX_W   (IDX_W)
    ) u_lut (
        .clk      (clk),
        .en       (adv),
        .addr     (k_cnt),
        .cos_coef (cos_p1),
        .sin_coef (sin_p1)
    );

    // S2: zero-extended coordinates times signed coefficients
    assign x_ext   = {{(COEF_W + 1){1'b0}}, x_q};
    assign y_ext   = {{(COEF_W + 1){1'b0}}, y_q};
    assign cos_ext = {{(XY_W + 1){cos_p1[COEF_W-1]}}, cos_p1};
    assign sin_ext = {{(XY_W + 1){sin_p1[COEF_W-1]}}, sin_p1};

    always_ff @(posedge clk) begin
        if (adv) begin
            k_p1  <= k_cnt;
            k_p2  <= k_p1;
            px_p2 <= x_ext * cos_ext;
            py_p2 <= y_ext * sin_ext;
        end
    end

    // S3: full-width sum, round half up, saturate into the output register
    assign sum_p3 = $signed({px_p2[PW-1], px_p2}) + $signed({py_p2[PW-1], py_p2});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            vld_p2    <= 1'b0;
            last_p2   <= 1'b0;
            out_vld   <= 1'b0;
            out_last  <= 1'b0;
            rho_data  <= '0;
            theta_idx <= '0;
        end else if (adv) begin
            vld_p1    <= issue;
            last_p1   <= issue && (k_cnt == KMAX);
            vld_p2    <= vld_p1;
            last_p2   <= last_p1;
            out_vld   <= vld_p2;
            out_last  <= last_p2;
            rho_data  <= sat_rho(round_q(sum_p3));
            theta_idx <= k_p2;
        end
    end

endmodule

// File: tb/tb_hough_rho_sweep.sv
// Directed bench for hough_rho_sweep: trig-level reference model with a
// scoreboard checked every cycle, plus literal expectations on known angles.
module tb_hough_rho_sweep;

    localparam int XY_W    = 12;
    localparam int THETA_N = 180;
    localparam int COEF_W  = 16;
    localparam int RHO_W   = XY_W + 2;
    localparam int IDX_W   = hough_pkg::idx_w(THETA_N);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    in_vld = 1'b0;
    logic                    out_rdy = 1'b1;
    logic [XY_W-1:0]         x = '0;
    logic [XY_W-1:0]         y = '0;
    logic                    in_rdy, out_vld, out_last;
    logic signed [RHO_W-1:0] rho_data;
    logic [IDX_W-1:0]        theta_idx;

    hough_rho_sweep #(
        .XY_W    (XY_W),
        .THETA_N (THETA_N),
        .COEF_W  (COEF_W),
        .RHO_W   (RHO_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .x         (x),
        .y         (y),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .rho_data  (rho_data),
        .theta_idx (theta_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rho;
        int k;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   n_pix_res = 0;
    int   lat_due = 0;
    bit   model_idle = 1'b1;
    bit   lat_pending = 1'b0;
    int   got[THETA_N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // rho from real-valued trig, coefficient rounded to Q2.14, then the
    // add-half / arithmetic-shift rounding and RHO_W saturation
    function automatic int model_rho(input int xx, input int yy, input int k);
        real    th, one;
        longint c, s, acc;
        one = 2.0 ** (COEF_W - 2);
        th  = 3.14159265358979323846 * k / THETA_N;
        c   = longint'($floor($cos(th) * one + 0.5));
        s   = longint'($floor($sin(th) * one + 0.5));
        acc = (longint'(xx) * c + longint'(yy) * s + (longint'(1) <<< (COEF_W - 3))) >>> (COEF_W - 2);
        if (acc > (2 ** (RHO_W - 1)) - 1) acc = (2 ** (RHO_W - 1)) - 1;
        if (acc < -(2 ** (RHO_W - 1)))    acc = -(2 ** (RHO_W - 1));
        return int'(acc);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("reset_out_vld", out_vld, 0);
            check("reset_out_last", out_last, 0);
            check("reset_rho_data", rho_data, 0);
            check("reset_theta_idx", theta_idx, 0);
            exp_q.delete();
            model_idle  = 1'b1;
            lat_pending = 1'b0;
        end else begin
            check("in_rdy", in_rdy, model_idle);
            if (lat_pending && cyc == lat_due) begin
                check("first_result_latency", out_vld, 1);
                lat_pending = 1'b0;
            end
            if (out_vld) begin
                if (lat_pending) begin
                    check("early_out_vld_cycle", cyc, lat_due);
                    lat_pending = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    check("spurious_out_vld", out_vld, 0);
                end else begin
                    e = exp_q[0];
                    check("rho_data", rho_data, e.rho);
                    check("theta_idx", theta_idx, e.k);
                    check("out_last", out_last, e.last);
                    if (out_rdy) begin
                        got[e.k] = int'(rho_data);
                        n_pix_res++;
                        void'(exp_q.pop_front());
                        if (e.last) begin
                            check("results_per_pixel", n_pix_res, THETA_N);
                            model_idle = 1'b1;
                        end
                    end
                end
            end
            if (in_vld && in_rdy) begin
                for (int k = 0; k < THETA_N; k++) begin
                    e.rho  = model_rho(int'(x), int'(y), k);
                    e.k    = k;
                    e.last = (k == THETA_N - 1);
                    exp_q.push_back(e);
                end
                model_idle  = 1'b0;
                lat_pending = 1'b1;
                lat_due     = cyc + 4;
                n_pix_res   = 0;
                n_acc++;
            end
        end
    end

    task automatic wait_done(input bit rnd);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (rnd) out_rdy = 1'($urandom_range(0, 1));
            if (model_idle && exp_q.size() == 0 && !lat_pending) begin
                done = 1'b1;
                break;
            end
        end
        out_rdy = 1'b1;
        check("sweep_done_in_budget", done, 1);
    endtask

    task automatic run_pixel(input int xx, input int yy, input bit rnd);
        x      = XY_W'(xx);
        y      = XY_W'(yy);
        in_vld = 1'b1;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        wait_done(rnd);
    endtask

    initial begin
        int tgt;
        bit found;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("model_100_100_k0", model_rho(100, 100, 0), 100);
        check("model_100_100_k45", model_rho(100, 100, 45), 141);
        check("model_100_100_k179", model_rho(100, 100, 179), -98);
        check("model_100_0_k120", model_rho(100, 0, 120), -50);
        check("model_4095_k179", model_rho(4095, 4095, 179), -4023);

        @(posedge clk);
        #1;
        run_pixel(100, 100, 1'b0);
        check("px100_100_k0", got[0], 100);
        check("px100_100_k45", got[45], 141);
        check("px100_100_k90", got[90], 100);
        check("px100_100_k135", got[135], 0);
        check("px100_100_k179", got[179], -98);

        run_pixel(100, 0, 1'b0);
        check("px100_0_k120", got[120], -50);
        check("px100_0_k60", got[60], 50);

        run_pixel(0, 0, 1'b0);
        for (int k = 0; k < THETA_N; k += 30) check("px0_0_zero", got[k], 0);

        run_pixel(4095, 4095, 1'b0);
        check("px4095_k45", got[45], 5791);
        check("px4095_k135", got[135], 0);
        check("px4095_k179", got[179], -4023);

        run_pixel(1234, 3210, 1'b1);
        run_pixel(4095, 17, 1'b1);

        // in_vld held high with fresh coordinates every cycle across two pixels
        tgt    = n_acc + 2;
        x      = XY_W'($urandom_range(0, 4095));
        y      = XY_W'($urandom_range(0, 4095));
        in_vld = 1'b1;
        for (int i = 0; i < 1000 && n_acc < tgt; i++) begin
            @(posedge clk);
            #1;
            x = XY_W'($urandom_range(0, 4095));
            y = XY_W'($urandom_range(0, 4095));
        end
        in_vld = 1'b0;
        check("held_in_vld_accepts", n_acc, tgt);
        wait_done(1'b0);

        // reset in the middle of a sweep
        x      = XY_W'(200);
        y      = XY_W'(300);
        in_vld = 1'b1;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (out_vld && theta_idx == 70) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_k70", found, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_out_vld", out_vld, 0);
        check("async_reset_in_rdy", in_rdy, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_pixel(50, 60, 1'b0);
        check("px50_60_k0", got[0], 50);
        check("px50_60_k90", got[90], 60);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
